// File: rtl/prz_pkg.sv
// Shared definitions for the pad bus controller: FSM state encoding and access size codes.
package prz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_TURN    = 3'd4
  } bus_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; the output is the last stage.
module pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: non-blocking assignment makes every stage take its neighbour's pre-edge
  // value, so the chain advances exactly one flop per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pad_bus_ctrl.sv
// Core-to-pad bus controller: 4-phase ready handshake with timeout, write turnaround,
// and synchronised interrupt / acknowledge channels.
module pad_bus_ctrl
  import prz_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int N_INTR      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              a_reset_l,
  input  logic              req,
  input  logic              wen,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              err,
  output logic [N_INTR-1:0] intr_h,
  input  logic [N_INTR-1:0] intr_ack,
  input  logic              pad_bus_rdy,
  input  logic [N_INTR-1:0] pad_intr_h,
  output logic              pad_bus_en,
  output logic              pad_bus_wen,
  output logic [1:0]        pad_bus_size,
  output logic [ADDR_W-1:0] pad_bus_addr,
  output logic [DATA_W-1:0] pad_data_o,
  output logic              pad_data_oe,
  input  logic [DATA_W-1:0] pad_data_i,
  output logic [N_INTR-1:0] pad_intr_ack
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  logic rdy_s;

  pad_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk   (clk),
    .rst_n (a_reset_l),
    .d     (pad_bus_rdy),
    .q     (rdy_s)
  );

  pad_sync #(.WIDTH(N_INTR), .STAGES(SYNC_STAGES)) u_intr_sync (
    .clk   (clk),
    .rst_n (a_reset_l),
    .d     (pad_intr_h),
    .q     (intr_h)
  );

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_wen_q, bus_wen_d;
  logic [1:0]        bus_size_q, bus_size_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [N_INTR-1:0] ack_q, ack_d;

  // NOTE: every _d starts from its hold value (or pulse default) so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    turn_d     = turn_q;
    bus_en_d   = bus_en_q;
    bus_wen_d  = bus_wen_q;
    bus_size_d = bus_size_q;
    bus_addr_d = bus_addr_q;
    data_o_d   = data_o_q;
    oe_d       = oe_q;
    load_d     = load_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ack_d      = intr_ack;

    unique case (state_q)
      ST_IDLE: begin
        // A ready still high from an earlier cycle is deliberately not looked at here.
        if (req) begin
          bus_en_d   = 1'b1;
          bus_wen_d  = wen;
          bus_size_d = size;
          bus_addr_d = addr;
          data_o_d   = store_data;
          oe_d       = wen;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Data is stable once the synchronised ready is seen, so it is sampled directly.
        if (rdy_s) begin
          if (!bus_wen_q) load_d = pad_data_i;
          done_d   = 1'b1;
          bus_en_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          done_d   = 1'b1;
          err_d    = 1'b1;
          bus_en_d = 1'b0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!rdy_s) begin
          if (bus_wen_q) begin
            oe_d    = 1'b0;
            turn_d  = '0;
            state_d = ST_TURN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) state_d = ST_IDLE;
        else                     turn_d  = turn_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      turn_q     <= '0;
      bus_en_q   <= 1'b0;
      bus_wen_q  <= 1'b0;
      bus_size_q <= '0;
      bus_addr_q <= '0;
      data_o_q   <= '0;
      oe_q       <= 1'b0;
      load_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
      bus_en_q   <= bus_en_d;
      bus_wen_q  <= bus_wen_d;
      bus_size_q <= bus_size_d;
      bus_addr_q <= bus_addr_d;
      data_o_q   <= data_o_d;
      oe_q       <= oe_d;
      load_q     <= load_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
    end
  end

  assign pad_bus_en   = bus_en_q;
  assign pad_bus_wen  = bus_wen_q;
  assign pad_bus_size = bus_size_q;
  assign pad_bus_addr = bus_addr_q;
  assign pad_data_o   = data_o_q;
  assign pad_data_oe  = oe_q;
  assign load_data    = load_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pad_intr_ack = ack_q;

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Self-checking bench for pad_bus_ctrl: vector table with a done-driven scoreboard,
// plus hand sequences for reset, interrupts, stale ready and back-to-back accesses.
module tb_pad_bus_ctrl;
  import prz_pkg::*;

  localparam int SYNC = 2;
  localparam int TURN = 2;
  localparam int TMO  = 4;

  logic        clk;
  logic        a_reset_l;
  logic        req, wen;
  logic [1:0]  size;
  logic [15:0] addr;
  logic [31:0] store_data, load_data;
  logic        done, err;
  logic [1:0]  intr_h, intr_ack, pad_intr_h, pad_intr_ack;
  logic        pad_bus_rdy, pad_bus_en, pad_bus_wen, pad_data_oe;
  logic [1:0]  pad_bus_size;
  logic [15:0] pad_bus_addr;
  logic [31:0] pad_data_o, pad_data_i;

  pad_bus_ctrl #(
    .ADDR_W(16), .DATA_W(32), .N_INTR(2),
    .SYNC_STAGES(SYNC), .TURN_CYC(TURN), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .a_reset_l(a_reset_l), .req(req), .wen(wen), .size(size),
    .addr(addr), .store_data(store_data), .load_data(load_data), .done(done),
    .err(err), .intr_h(intr_h), .intr_ack(intr_ack), .pad_bus_rdy(pad_bus_rdy),
    .pad_intr_h(pad_intr_h), .pad_bus_en(pad_bus_en), .pad_bus_wen(pad_bus_wen),
    .pad_bus_size(pad_bus_size), .pad_bus_addr(pad_bus_addr),
    .pad_data_o(pad_data_o), .pad_data_oe(pad_data_oe), .pad_data_i(pad_data_i),
    .pad_intr_ack(pad_intr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          stall;
    logic        exp_err;
    logic [31:0] exp_load;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] load;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus device: raises ready dev_delay cycles after seeing the strobe, drops it 4-phase.
  int          dev_delay = 0;
  bit          dev_stall = 1'b0;
  bit          dev_stale = 1'b0;
  logic [31:0] dev_data  = '0;
  int          dev_cnt   = 0;

  initial begin
    pad_bus_rdy = 1'b0;
    pad_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (!a_reset_l) begin
        pad_bus_rdy = 1'b0;
        dev_cnt     = 0;
      end else if (dev_stale) begin
        pad_bus_rdy = 1'b1;
      end else if (!pad_bus_en) begin
        pad_bus_rdy = 1'b0;
        dev_cnt     = 0;
      end else if (!pad_bus_rdy && !dev_stall) begin
        if (dev_cnt >= dev_delay) begin
          pad_bus_rdy = 1'b1;
          pad_data_i  = dev_data;
        end else begin
          pad_data_i = ~dev_data;
          dev_cnt++;
        end
      end
    end
  end

  // Monitor: scoreboard pop on done, strobe/oe invariants, turnaround gap.
  int  done_cnt = 0;
  int  en_rises = 0;
  bit  en_prev = 1'b0, oe_prev = 1'b0, done_prev = 1'b0;
  bit  oe_bad = 1'b0, gap_armed = 1'b0;
  int  gap = 0;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (pad_bus_en && !en_prev) begin
        en_rises++;
        oe_bad = 1'b0;
        if (gap_armed) begin
          check("turn_gap_min", gap >= TURN, 1'b1);
          gap_armed = 1'b0;
        end
      end
      if (pad_bus_en && (pad_data_oe !== pad_bus_wen)) oe_bad = 1'b1;
      if (pad_data_oe && !pad_bus_wen) oe_bad = 1'b1;
      if (oe_prev && !pad_data_oe) begin
        gap_armed = 1'b1;
        gap       = 0;
      end
      if (gap_armed && !pad_data_oe && !pad_bus_en) gap++;
      if (done_prev) check("done_one_cycle", done, 1'b0);
      if (done) begin
        done_cnt++;
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("err", err, e.err);
          check("load_data", load_data, e.load);
          check("bus_addr", pad_bus_addr, e.addr);
          check("bus_size", pad_bus_size, e.size);
          check("bus_wen", pad_bus_wen, e.wen);
          check("oe_in_release", pad_data_oe, e.wen);
          check("oe_tracks_wen", oe_bad, 1'b0);
          if (e.wen) check("pad_data_o", pad_data_o, e.wdata);
        end
      end
      en_prev   = pad_bus_en;
      oe_prev   = pad_data_oe;
      done_prev = done;
    end
  end

  task automatic do_txn(input vec_t v, output int lat);
    sb_t e;
    @(negedge clk);
    dev_delay = v.delay;
    dev_stall = v.stall;
    dev_data  = v.rdata;
    e = '{v.wen, v.addr, v.size, v.wdata, v.exp_err, v.exp_load};
    sb.push_back(e);
    req = 1'b1; wen = v.wen; size = v.size; addr = v.addr; store_data = v.wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    req = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    int lat, n, d0, r0;
    vec_t v;

    vecs[0] = '{1'b0, 16'h1234, SIZE_WORD, 32'h0000_0000, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 7};
    vecs[1] = '{1'b1, 16'h0040, SIZE_WORD, 32'hA5A5_A5A5, 32'h0000_0000, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4};
    vecs[2] = '{1'b0, 16'h0002, SIZE_HALF, 32'h1111_1111, 32'h0000_CAFE, 1, 1'b0, 1'b0, 32'h0000_CAFE, 5};
    vecs[3] = '{1'b0, 16'h0800, SIZE_WORD, 32'h0000_0000, 32'h7777_7777, 0, 1'b1, 1'b1, 32'h0000_CAFE, 7};
    vecs[4] = '{1'b1, 16'h0804, SIZE_WORD, 32'h1234_5678, 32'h0000_0000, 0, 1'b1, 1'b1, 32'h0000_CAFE, 7};
    vecs[5] = '{1'b0, 16'hFFFF, SIZE_BYTE, 32'h0000_0000, 32'h0000_005A, 2, 1'b0, 1'b0, 32'h0000_005A, 6};
    vecs[6] = '{1'b1, 16'hFFFF, SIZE_BYTE, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_005A, 4};
    vecs[7] = '{1'b0, 16'h0000, SIZE_WORD, 32'h0000_0000, 32'h1357_9BDF, 0, 1'b0, 1'b0, 32'h1357_9BDF, 4};

    a_reset_l = 1'b0;
    req = 1'b0; wen = 1'b0; size = '0; addr = '0; store_data = '0;
    intr_ack = 2'b11; pad_intr_h = 2'b11;

    // Reset holds everything low even with active pad inputs.
    repeat (3) @(negedge clk);
    check("rst_load_data", load_data, 32'h0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_bus_strobes", {pad_bus_en, pad_bus_wen, pad_data_oe}, 3'b000);
    check("rst_bus_addr", pad_bus_addr, 16'h0);
    check("rst_data_o", pad_data_o, 32'h0);
    check("rst_intr", {intr_h, pad_intr_ack}, 4'b0000);
    a_reset_l = 1'b1;
    intr_ack = 2'b00; pad_intr_h = 2'b00;
    repeat (5) @(negedge clk);

    // Interrupt synchroniser depth and ack register.
    @(posedge clk); #1;
    pad_intr_h = 2'b10;
    intr_ack   = 2'b01;
    check("ack_not_comb", pad_intr_ack, 2'b00);
    repeat (SYNC - 1) @(posedge clk);
    #1;
    check("intr_h_early", intr_h, 2'b00);
    check("pad_intr_ack", pad_intr_ack, 2'b01);
    @(posedge clk); #1;
    check("intr_h_sync", intr_h, 2'b10);
    pad_intr_h = 2'b00; intr_ack = 2'b00;
    repeat (5) @(negedge clk);

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], lat);
      check($sformatf("latency_v%0d", i), lat, vecs[i].exp_lat);
    end

    // Stale ready in IDLE must not start anything.
    d0 = done_cnt; r0 = en_rises;
    dev_stale = 1'b1;
    repeat (8) @(negedge clk);
    check("stale_no_strobe", en_rises, r0);
    check("stale_no_done", done_cnt, d0);
    dev_stale = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during WAIT of a write.
    @(negedge clk);
    dev_stall = 1'b1;
    req = 1'b1; wen = 1'b1; size = SIZE_WORD; addr = 16'h0300; store_data = 32'hFEED_FACE;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pad_bus_en && n < 10);
    repeat (2) @(negedge clk);
    check("pre_rst_oe", {pad_data_oe, pad_bus_en}, 2'b11);
    d0 = done_cnt;
    a_reset_l = 1'b0;
    #1;
    check("rst_async_oe_en", {pad_data_oe, pad_bus_en}, 2'b00);
    req = 1'b0; dev_stall = 1'b0;
    @(negedge clk);
    a_reset_l = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_done", done_cnt, d0);
    v = '{1'b0, 16'h0ABC, SIZE_WORD, 32'h0, 32'h600D_CAFE, 1, 1'b0, 1'b0, 32'h600D_CAFE, 5};
    do_txn(v, lat);
    check("post_rst_latency", lat, 5);

    // Back-to-back with req held: write then read.
    d0 = done_cnt; r0 = en_rises;
    @(negedge clk);
    dev_delay = 0; dev_stall = 1'b0; dev_data = 32'h0BAD_F00D;
    sb.push_back('{1'b1, 16'h0100, SIZE_WORD, 32'h1122_3344, 1'b0, 32'h600D_CAFE});
    sb.push_back('{1'b0, 16'h0200, SIZE_WORD, 32'h0, 1'b0, 32'h0BAD_F00D});
    req = 1'b1; wen = 1'b1; size = SIZE_WORD; addr = 16'h0100; store_data = 32'h1122_3344;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    wen = 1'b0; addr = 16'h0200; store_data = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b_two_dones", done_cnt - d0, 2);
    check("b2b_strobe_dropped", en_rises - r0, 2);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pad_bus_ctrl.md
PAD_BUS_CTRL -- requirements
Module: pad_bus_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDR_W, 16, external address width;
  DATA_W, 32, external data width (multiple of 8);
  N_INTR, 2, interrupt/ack channel count;
  SYNC_STAGES, 2, flops per input synchroniser (min 2);
  TURN_CYC, 1, bus turnaround cycles after a write (min 1);
  TIMEOUT, 255, max WAIT cycles before abort (min 1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock;
  a_reset_l  in  1  async active-low reset;
  req  in  1  core request, level, held until done;
  wen  in  1  1=write, 0=read;
  size  in  2  access size (00 byte, 01 half, 10 word);
  addr  in  ADDR_W  core address;
  store_data  in  DATA_W  core write data;
  load_data  out  DATA_W  read data captured from bus;
  done  out  1  one-cycle completion pulse;
  err  out  1  timeout flag, valid with done;
  intr_h  out  N_INTR  synchronised interrupt levels to core;
  intr_ack  in  N_INTR  core interrupt acknowledge;
  pad_bus_rdy  in  1  async external ready;
  pad_intr_h  in  N_INTR  async external interrupts;
  pad_bus_en, pad_bus_wen  out  1  registered bus strobes;
  pad_bus_size  out  2  registered size;
  pad_bus_addr  out  ADDR_W  registered address;
  pad_data_o  out  DATA_W  registered write data;
  pad_data_oe  out  1  data pad output enable;
  pad_data_i  in  DATA_W  data pad input;
  pad_intr_ack  out  N_INTR  registered ack.
REQ-003 Clock is clk only; reset is a_reset_l, asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, ADDR, WAIT, RELEASE, TURN.
REQ-005 IDLE: req=1 -> register addr/size/wen/store_data onto pad outputs, go ADDR; req=0 -> stay.
REQ-006 ADDR (one cycle): pad_bus_en=1; pad_data_oe=wen; go WAIT; timeout counter cleared.
REQ-007 WAIT: rdy_s (pad_bus_rdy after SYNC_STAGES flops) =1 -> for reads capture pad_data_i into load_data; pulse done, err=0; go RELEASE.
REQ-008 WAIT: counter reaching TIMEOUT with rdy_s=0 -> pulse done with err=1, load_data unchanged, go RELEASE.
REQ-009 RELEASE: pad_bus_en=0; pad_data_oe held; wait for rdy_s=0 (4-phase handshake), then go TURN if last access was a write, else IDLE.
REQ-010 TURN: pad_data_oe=0 for TURN_CYC cycles, then IDLE; no request accepted.
REQ-011 pad_data_oe SHALL be 1 only from ADDR through RELEASE of a write; never 1 during a read.
REQ-012 done SHALL be exactly one cycle; req must drop after done; req still high in IDLE starts a new access.
REQ-013 Request-to-done latency = 2 + SYNC_STAGES cycles minimum with ready already high.
REQ-014 pad_intr_h SHALL pass through SYNC_STAGES flops to intr_h; intr_ack registered one cycle to pad_intr_ack.
REQ-015 Timeout counter width = clog2(TIMEOUT+1); saturates, never wraps.
REQ-016 rdy_s high in IDLE (stale ready) SHALL be ignored; WAIT is entered only via ADDR.

Reset
REQ-017 Asserted a_reset_l SHALL immediately force IDLE, all pad outputs, pad_data_oe, done, err, load_data, intr_h, synchroniser flops to 0.
REQ-018 Reset mid-transaction SHALL abort without a done pulse; oe releases asynchronously.

Structure
REQ-019 State encoding and size codes SHALL live in shared package prz_pkg.
REQ-020 Synchroniser SHALL be sub-module pad_sync (parameterised width, stages), used for ready and interrupts.

Verification
REQ-021 Read: addr=0x1234, ready after 3 cycles, pad_data_i=0xDEADBEEF -> load_data=0xDEADBEEF, done one cycle, err=0, oe never 1.
REQ-022 Write: store_data=0xA5A5A5A5 -> pad_data_o=0xA5A5A5A5, oe 1 ADDR..RELEASE, then 0 for TURN_CYC cycles before next ADDR.
REQ-023 Timeout: TIMEOUT=4, ready held low -> done with err=1 on 5th WAIT cycle, load_data unchanged.
REQ-024 Reset in WAIT of a write -> oe and pad_bus_en 0 same cycle, no done, next req serviced normally.
REQ-025 pad_intr_h=2'b10 -> intr_h=2'b10 after exactly SYNC_STAGES edges; intr_ack=2'b01 -> pad_intr_ack=2'b01 next cycle.
REQ-026 Back-to-back: req held, ready toggling 4-phase -> two done pulses, pad_bus_en low between accesses.
